// File: rtl/mips_multi_hs.sv
// Multicycle MIPS core (lw/sw/R-type/addi/beq/bne/j) with a req/ready unified memory port.
// Optional perf counters (cycle_cnt, instret_cnt) are built when MIPS_PERF_CNT_EN is defined.
module mips_multi_hs #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned HALT_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_out,
    output logic        halted
`ifdef MIPS_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        StStart, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExec, StAluWb, StAddiEx, StAddiWb, StBranch, StJump, StHalt
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    state_e      r_state, w_state_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_simm, w_alu_res;
    logic        w_funct_ok, w_take, w_req;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    state_e      w_illegal_next;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_take  = (w_op == OpBne) ? (r_a != r_b) : (r_a == r_b);
    assign w_illegal_next = (HALT_ON_ILLEGAL != 0) ? StHalt : StFetch;

    always_comb begin
        w_alu_res  = '0;
        w_funct_ok = 1'b1;
        case (w_funct)
            6'h20:   w_alu_res = r_a + r_b;
            6'h22:   w_alu_res = r_a - r_b;
            6'h24:   w_alu_res = r_a & r_b;
            6'h25:   w_alu_res = r_a | r_b;
            6'h2A:   w_alu_res = {31'b0, $signed(r_a) < $signed(r_b)};
            default: w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_pc;
        mem_wdata    = '0;
        w_rf_we      = 1'b0;
        w_rf_waddr   = w_rt;
        w_rf_wdata   = r_alu;
        unique case (r_state)
            StStart:  w_state_next = StFetch;
            StFetch: begin
                w_req = 1'b1;
                if (mem_ready) w_state_next = StDecode;
            end
            StDecode: begin
                case (w_op)
                    OpLw, OpSw:   w_state_next = StMemAdr;
                    OpRtype:      w_state_next = StExec;
                    OpAddi:       w_state_next = StAddiEx;
                    OpBeq, OpBne: w_state_next = StBranch;
                    OpJ:          w_state_next = StJump;
                    default:      w_state_next = w_illegal_next;
                endcase
            end
            StMemAdr: w_state_next = (w_op == OpLw) ? StMemRd : StMemWr;
            StMemRd: begin
                w_req    = 1'b1;
                mem_addr = r_alu;
                if (mem_ready) w_state_next = StMemWb;
            end
            StMemWb: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = r_mdr;
                w_state_next = StFetch;
            end
            StMemWr: begin
                w_req     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_alu;
                mem_wdata = r_b;
                if (mem_ready) w_state_next = StFetch;
            end
            StExec:   w_state_next = w_funct_ok ? StAluWb : w_illegal_next;
            StAluWb: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = w_rd;
                w_state_next = StFetch;
            end
            StAddiEx: w_state_next = StAddiWb;
            StAddiWb: begin
                w_rf_we      = 1'b1;
                w_state_next = StFetch;
            end
            StBranch: w_state_next = StFetch;
            StJump:   w_state_next = StFetch;
            StHalt:   w_state_next = StHalt;
            default:  w_state_next = StHalt;
        endcase
    end

    // Gate with reset so the request drops the instant reset asserts.
    assign mem_req = w_req & reset;
    assign pc_out  = r_pc;
    assign halted  = (r_state == StHalt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StStart;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StFetch: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                StDecode: begin
                    r_a   <= r_rf[w_rs];
                    r_b   <= r_rf[w_rt];
                    r_alu <= r_pc + (w_simm << 2);
                end
                StMemAdr: r_alu <= r_a + w_simm;
                StMemRd:  if (mem_ready) r_mdr <= mem_rdata;
                StExec:   r_alu <= w_alu_res;
                StAddiEx: r_alu <= r_a + w_simm;
                StBranch: if (w_take) r_pc <= r_alu;
                StJump:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default:  ;
            endcase
        end
    end

    // r0 is never written, so it always reads back as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

`ifdef MIPS_PERF_CNT_EN
    logic [31:0] r_cycle_cnt, r_instret_cnt;
    logic        w_retire;

    // Any entry into FETCH from a state other than START/FETCH retires one instruction.
    assign w_retire = (w_state_next == StFetch) && (r_state != StStart) && (r_state != StFetch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if ((r_state != StStart) && (r_state != StHalt)) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule
